// File: rtl/piso_serializer_if.sv
// Handshake bundle for the parallel-in / serial-out serializer.
// The slave modport is the serializer side; the master modport is the producer/consumer side.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] data_i;
    logic         load_valid_i;
    logic         load_ready_o;
    logic         ser_o;
    logic         ser_valid_o;
    logic         ser_ready_i;
    logic         busy_o;
    logic         done_o;

    modport slave (
        input  data_i,
        input  load_valid_i,
        output load_ready_o,
        output ser_o,
        output ser_valid_o,
        input  ser_ready_i,
        output busy_o,
        output done_o
    );

    modport master (
        output data_i,
        output load_valid_i,
        input  load_ready_o,
        input  ser_o,
        input  ser_valid_o,
        output ser_ready_i,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/piso_serializer.sv
// N-bit parallel-in / serial-out shifter, LSB first, with valid/ready on both sides
// and a one-cycle done pulse after the last bit of each word is accepted.
module piso_serializer #(
    parameter int N = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    piso_serializer_if.slave     bus
);
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // State register with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load in IDLE, shift on each accepted bit in SHIFT
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_valid_i) begin
                    shreg_d = bus.data_i;
                    cnt_d   = CNT_W'(N - 1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.ser_ready_i) begin
                    if (cnt_q != '0) begin
                        shreg_d = {1'b0, shreg_q[N-1:1]};
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        // Last bit accepted: clear so ser_o reads 0 while idle
                        shreg_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake flags depend on state alone so neither side sees a combinational loop
    assign bus.load_ready_o = (state_q == IDLE);
    assign bus.ser_valid_o  = (state_q == SHIFT);
    assign bus.busy_o       = (state_q == SHIFT);
    assign bus.ser_o        = shreg_q[0];
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (N=8): directed scenarios plus random words
// and random downstream back-pressure, compared against a bit-extraction reference.
module tb_piso_serializer;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    piso_serializer_if #(.N(N)) bus ();

    piso_serializer #(.N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit k of the serial stream is simply bit k of the loaded word.
    function automatic logic ref_bit(input logic [N-1:0] w, input int k);
        return 1'((w >> k) & 1);
    endfunction

    // mode: 0 = ready always 1, 1 = ready toggling 1,0,1,..., 2 = random ready
    task automatic send_word(input logic [N-1:0] w, input int mode, input logic lv_during,
                             input string name);
        int idx;
        int cyc;
        logic rdy;
        bus.data_i       = w;
        bus.load_valid_i = 1'b1;
        checks++;
        if (bus.load_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s load_ready before load: got %b want 1", name, bus.load_ready_o);
        end
        tick();
        bus.load_valid_i = lv_during;
        bus.data_i       = ~w;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 64) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.ser_ready_i = rdy;
            checks++;
            if (bus.ser_valid_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.load_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s shift flags cyc %0d: valid=%b busy=%b ready=%b want 1 1 0",
                         name, cyc, bus.ser_valid_o, bus.busy_o, bus.load_ready_o);
            end
            checks++;
            if (bus.ser_o !== ref_bit(w, idx)) begin
                errors++;
                $display("FAIL %s ser_o bit %0d cyc %0d: got %b want %b",
                         name, idx, cyc, bus.ser_o, ref_bit(w, idx));
            end
            checks++;
            if (bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s early done cyc %0d: got %b want 0", name, cyc, bus.done_o);
            end
            tick();
            cyc++;
            if (rdy) idx++;
        end
        bus.load_valid_i = 1'b0;
        bus.ser_ready_i  = 1'($urandom_range(0, 1));
        checks++;
        if (idx != N) begin
            errors++;
            $display("FAIL %s timeout: transferred %0d want %0d", name, idx, N);
        end
        checks++;
        if (bus.done_o !== 1'b1 || bus.load_ready_o !== 1'b1 || bus.ser_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.ser_o !== 1'b0) begin
            errors++;
            $display("FAIL %s end cycle: done=%b ready=%b valid=%b busy=%b ser=%b want 1 1 0 0 0",
                     name, bus.done_o, bus.load_ready_o, bus.ser_valid_o, bus.busy_o, bus.ser_o);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != N) begin
                errors++;
                $display("FAIL %s shift length: got %0d want %0d", name, cyc, N);
            end
        end
        tick();
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done after pulse: done=%b busy=%b want 0 0", name, bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ser_o !== 1'b0 || bus.ser_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.load_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: ser=%b valid=%b busy=%b ready=%b done=%b want 0 0 0 1 0",
                     bus.ser_o, bus.ser_valid_o, bus.busy_o, bus.load_ready_o, bus.done_o);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_a5();
        send_word(8'hA5, 0, 1'b0, "word_a5");
    endtask

    task automatic test_backpressure();
        send_word(8'h81, 1, 1'b0, "toggle_81");
    endtask

    task automatic test_ignore_load();
        send_word(8'hFF, 0, 1'b1, "ignore_ff");
    endtask

    task automatic test_reset_mid();
        bus.data_i       = 8'h3C;
        bus.load_valid_i = 1'b1;
        bus.ser_ready_i  = 1'b1;
        tick();
        bus.load_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.ser_o !== ref_bit(8'h3C, 3) || bus.ser_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid before reset: ser=%b valid=%b want %b 1",
                     bus.ser_o, bus.ser_valid_o, ref_bit(8'h3C, 3));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.ser_o !== 1'b0 || bus.ser_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.load_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid async: ser=%b valid=%b busy=%b ready=%b done=%b want 0 0 0 1 0",
                     bus.ser_o, bus.ser_valid_o, bus.busy_o, bus.load_ready_o, bus.done_o);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (bus.done_o !== 1'b0 || bus.ser_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid after release: done=%b valid=%b want 0 0", bus.done_o, bus.ser_valid_o);
        end
        send_word(8'h01, 0, 1'b0, "after_rst_01");
    endtask

    task automatic test_back_to_back();
        int nvalid;
        logic expb;
        bus.data_i       = 8'h0F;
        bus.load_valid_i = 1'b1;
        bus.ser_ready_i  = 1'b1;
        tick();
        bus.data_i = 8'hF0;
        nvalid = 0;
        for (int c = 0; c < 2 * N + 1; c++) begin
            if (c == N) begin
                checks++;
                if (bus.ser_valid_o !== 1'b0 || bus.done_o !== 1'b1 || bus.load_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b gap cycle: valid=%b done=%b ready=%b want 0 1 1",
                             bus.ser_valid_o, bus.done_o, bus.load_ready_o);
                end
            end else begin
                expb = (c < N) ? ref_bit(8'h0F, c) : ref_bit(8'hF0, c - N - 1);
                checks++;
                if (bus.ser_valid_o !== 1'b1 || bus.ser_o !== expb || bus.done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b cycle %0d: valid=%b ser=%b done=%b want 1 %b 0",
                             c, bus.ser_valid_o, bus.ser_o, bus.done_o, expb);
                end
            end
            if (bus.ser_valid_o === 1'b1) nvalid++;
            tick();
            if (c == N) bus.load_valid_i = 1'b0;
        end
        checks++;
        if (nvalid != 2 * N || bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b totals: bits=%0d done=%b want %0d 1", nvalid, bus.done_o, 2 * N);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            send_word(8'($urandom), 2, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst              = 1'b1;
        bus.data_i       = '0;
        bus.load_valid_i = 1'b0;
        bus.ser_ready_i  = 1'b0;
        test_reset();
        test_a5();
        test_backpressure();
        test_ignore_load();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
